fb_arbiter: RTL

Controller that shares the single-port 6-bit frame buffer RAM between the MCU pixel-write path (after SPI decode) and the LCD scan-out read path. Scan reads have strict priority; MCU writes are buffered in a small FIFO and retired in idle RAM cycles. A draw scheduler turns MCU refresh requests into a single `draw` pulse to the LCD timing sequencer, but only after all pending writes are in RAM. A scan watchdog recovers the scheduler if the sequencer never reports frame completion.

---
 rtl/fb_arbiter_if.sv | 53 +++++
 rtl/fb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: bundles the MCU write port, scan-out read port, frame buffer
// RAM port and draw scheduler handshake of the frame buffer arbiter.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system (MCU path, LCD sequencer and RAM).
interface fb_arbiter_if #(
    parameter int DATAW = 6,
    parameter int ADDRW = 15
);
    logic             wr_valid;
    logic [ADDRW-1:0] wr_addr;
    logic [DATAW-1:0] wr_data;
    logic             wr_ready;

    logic             rd_req;
    logic [ADDRW-1:0] rd_addr;
    logic             rd_valid;
    logic [DATAW-1:0] rd_data;

    logic [ADDRW-1:0] ram_addr;
    logic [DATAW-1:0] ram_din;
    logic             ram_we;
    logic             ram_re;
    logic [DATAW-1:0] ram_dout;

    logic             draw_req;
    logic             frame_done;
    logic             draw;
    logic             busy;
    logic [7:0]       frames;
    logic             scan_err;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_req, rd_addr,
        output rd_valid, rd_data,
        output ram_addr, ram_din, ram_we, ram_re,
        input  ram_dout,
        input  draw_req, frame_done,
        output draw, busy, frames, scan_err
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_req, rd_addr,
        input  rd_valid, rd_data,
        input  ram_addr, ram_din, ram_we, ram_re,
        output ram_dout,
        output draw_req, frame_done,
        input  draw, busy, frames, scan_err
    );
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares the single-port frame buffer RAM between the LCD scan-out
// reads (strict priority) and buffered MCU pixel writes, and schedules frame
// draws so that a draw only starts once every queued write has reached RAM.
// A watchdog pulls the scheduler out of SCAN if the sequencer never reports
// frame completion.
module fb_arbiter #(
    parameter int DATAW        = 6,
    parameter int ADDRW        = 15,
    parameter int FIFO_DEPTH   = 4,
    parameter int SCAN_TIMEOUT = 80000
) (
    input  logic        clock,
    input  logic        reset,
    fb_arbiter_if.slave bus
);

    localparam int PTRW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FIRE,
        SCAN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDRW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATAW-1:0] fifo_data [FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW:0]    count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             wr_ready;

    logic [ADDRW-1:0] ram_addr;
    logic [DATAW-1:0] ram_din;
    logic             ram_we;
    logic             ram_re;

    logic             rd_valid_q;
    logic             pending;
    logic [16:0]      wdog;
    logic [7:0]       frames_q;
    logic             scan_err_q;
    logic             frame_hit;
    logic             timeout_hit;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTRW+1)'(FIFO_DEPTH));

    // Writes are held off while draining so the draw sees a settled frame
    // buffer; the reset term keeps the port closed during the reset cycle.
    assign wr_ready = !reset && !fifo_full && (state != DRAIN);
    assign push     = bus.wr_valid && wr_ready;
    assign pop      = !reset && !bus.rd_req && !fifo_empty;

    // FIFO storage needs no reset: only entries between the pointers are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy; a push and pop in the same cycle cancel.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            if (push && !pop) begin
                count <= count + (PTRW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTRW+1)'(1);
            end
        end
    end

    // Fixed-priority RAM port mux: scan read first, then the FIFO head.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        if (!reset) begin
            if (bus.rd_req) begin
                ram_addr = bus.rd_addr;
                ram_re   = 1'b1;
            end else if (!fifo_empty) begin
                ram_addr = fifo_addr[rd_ptr];
                ram_din  = fifo_data[rd_ptr];
                ram_we   = 1'b1;
            end
        end
    end

    // Read-valid tracks the read strobe one cycle later; the data itself is
    // the RAM's registered output, so it is only qualified here.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scheduler next state. DRAIN may leave on the cycle that retires the last
    // queued write, since that write lands in RAM on the same edge.
    always_comb begin
        state_next  = state;
        frame_hit   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.draw_req || pending) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.rd_req && (fifo_empty || count == (PTRW+1)'(1))) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                state_next = SCAN;
            end
            SCAN: begin
                if (bus.frame_done) begin
                    frame_hit  = 1'b1;
                    state_next = IDLE;
                end else if (wdog == 17'(SCAN_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending latch merges requests seen while a draw is in progress; a
    // request arriving in FIRE itself wins over the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (bus.draw_req && state != IDLE) begin
            pending <= 1'b1;
        end else if (state == FIRE) begin
            pending <= 1'b0;
        end
    end

    // Watchdog restarts at each draw and counts SCAN cycles, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog <= '0;
        end else if (state == FIRE) begin
            wdog <= '0;
        end else if (state == SCAN && wdog != 17'(SCAN_TIMEOUT)) begin
            wdog <= wdog + 17'd1;
        end
    end

    // Frame counter and sticky watchdog error.
    always_ff @(posedge clock) begin
        if (reset) begin
            frames_q   <= '0;
            scan_err_q <= 1'b0;
        end else begin
            if (frame_hit) begin
                frames_q <= frames_q + 8'd1;
            end
            if (timeout_hit) begin
                scan_err_q <= 1'b1;
            end
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.ram_addr = ram_addr;
    assign bus.ram_din  = ram_din;
    assign bus.ram_we   = ram_we;
    assign bus.ram_re   = ram_re;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_valid_q ? bus.ram_dout : '0;
    assign bus.draw     = (state == FIRE);
    assign bus.busy     = (state != IDLE);
    assign bus.frames   = frames_q;
    assign bus.scan_err = scan_err_q;

endmodule
